tff_count_sequencer: RTL

Controller that sequences a bank of toggle flip-flops as a programmable up/down counter. It drives the per-bit T enables, initialises the bank through toggles only (no parallel load path), and runs it to a latched terminal value under a start/stop handshake. It sits above the T flip-flop datapath as its only driver and exposes busy/done status to the surrounding control logic.

---
 rtl/tff_seq_pkg.sv | 15 +
 rtl/tff_bank.sv | 28 ++
 rtl/tff_count_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/tff_seq_pkg.sv
// Shared state encoding and direction constants for the toggle-flip-flop count sequencer.
package tff_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        RUN  = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } seq_state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_bank.sv
// Bank of toggle flip-flops: each bit flips on the rising edge when its T enable is high.
module tff_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q ^ t_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/tff_count_sequencer.sv
// Sequences a T flip-flop bank as an up/down counter: toggle-only initialisation,
// stepping to a latched terminal value, with start/stop pause, resume and abort.
module tff_count_sequencer
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_dbg
);

    // Control handshake: start and stop are level requests sampled on every rising
    // edge; there is no ready/ack. stop always has priority over start, and each is
    // honoured only in the states where it has a meaning (start in IDLE/HOLD, stop in
    // RUN/HOLD). done is a one-cycle completion strobe; busy covers INIT, RUN and HOLD.

    seq_state_e       state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] limit_q, limit_d;

    logic [WIDTH-1:0] init_val;
    logic [WIDTH-1:0] target_val;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] down_t;
    logic             carry_up;
    logic             carry_dn;

    tff_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk (clk),
        .rst (rst),
        .t_i (t_vec),
        .q_o (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            limit_q <= limit_d;
        end
    end

    // Step enables: bit i toggles when all lower bits are 1 (up) or all 0 (down).
    always_comb begin
        init_val   = (dir_q == DIR_UP) ? '0 : limit_q;
        target_val = (dir_q == DIR_UP) ? limit_q : '0;
        carry_up   = 1'b1;
        carry_dn   = 1'b1;
        up_t       = '0;
        down_t     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i]   = carry_up;
            down_t[i] = carry_dn;
            carry_up  = carry_up & count[i];
            carry_dn  = carry_dn & ~count[i];
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        limit_d = limit_q;
        t_vec   = '0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    dir_d   = dir;
                    limit_d = limit;
                    state_d = INIT;
                end
            end
            INIT: begin
                t_vec   = count ^ init_val;
                state_d = RUN;
            end
            RUN: begin
                // Terminal check precedes the step, so the bank never wraps.
                if (count == target_val) begin
                    state_d = DONE;
                end else if (stop) begin
                    state_d = HOLD;
                end else begin
                    t_vec = (dir_q == DIR_UP) ? up_t : down_t;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == INIT) || (state_q == RUN) || (state_q == HOLD);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

endmodule
